// File: rtl/rst_seq.sv
// Reset sequencer: asserts r1/r2 asynchronously on r, releases r2 then r1 in order
// after a hold period; a synchronous soft-reset request replays the same sequence.
module rst_seq #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD        = 8,
  parameter int unsigned GAP         = 4
) (
  input  logic       clk,
  input  logic       r,
  input  logic       req,
  output logic       r1,
  output logic       r2,
  output logic       ready,
  output logic [1:0] cause
);

  localparam int unsigned MAX_CNT = (HOLD > GAP) ? HOLD : GAP;
  localparam int unsigned CW      = $clog2(MAX_CNT) + 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP - 1);

  localparam logic [1:0] CAUSE_R   = 2'b01;
  localparam logic [1:0] CAUSE_REQ = 2'b10;

  typedef enum logic [1:0] {StAssert, StRel2, StRun} state_e;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rst_int;
  state_e                 r_state, w_state_nxt;
  logic [CW-1:0]          r_cnt, w_cnt_nxt;
  logic [1:0]             r_cause, w_cause_nxt;
  logic                   r_r1, r_r2, r_ready;

  // Assert asynchronously, release only after the chain has flushed with zeros.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b0};
    end
  end

  assign w_rst_int = r_sync[SYNC_STAGES-1];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cause_nxt = r_cause;
    unique case (r_state)
      StAssert: begin
        if (req) begin
          w_cnt_nxt = '0;
        end else if (!w_rst_int) begin
          if (r_cnt == HOLD_LAST) begin
            w_state_nxt = StRel2;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      StRel2: begin
        if (req) begin
          w_state_nxt = StAssert;
          w_cnt_nxt   = '0;
          w_cause_nxt = CAUSE_REQ;
        end else if (r_cnt == GAP_LAST) begin
          w_state_nxt = StRun;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      StRun: begin
        if (req) begin
          w_state_nxt = StAssert;
          w_cnt_nxt   = '0;
          w_cause_nxt = CAUSE_REQ;
        end
      end
      default: begin
        w_state_nxt = StAssert;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they change on the same edge as it.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      r_state <= StAssert;
      r_cnt   <= '0;
      r_cause <= CAUSE_R;
      r_r1    <= 1'b1;
      r_r2    <= 1'b1;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cause <= w_cause_nxt;
      r_r1    <= (w_state_nxt != StRun);
      r_r2    <= (w_state_nxt == StAssert);
      r_ready <= (w_state_nxt == StRun);
    end
  end

  assign r1    = r_r1;
  assign r2    = r_r2;
  assign ready = r_ready;
  assign cause = r_cause;

endmodule

// File: tb/tb_rst_seq.sv
// Scoreboard bench for rst_seq: stimulus queues expected release events, a monitor
// pops and checks them as they appear, and checks the r1/r2/ready invariants every cycle.
module tb_rst_seq;

  localparam int R2F = 0;
  localparam int RDY = 1;

  logic       clk = 1'b0;
  logic       r;
  logic       req;
  logic       r1;
  logic       r2;
  logic       ready;
  logic [1:0] cause;

  typedef struct {
    int         kind;
    int         cyc;
    logic [1:0] cause;
  } ev_t;

  ev_t  sb_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   sb_en = 1'b1;
  logic prev_r2 = 1'b1;
  logic prev_rdy = 1'b0;

  rst_seq #(
    .SYNC_STAGES(2),
    .HOLD       (8),
    .GAP        (4)
  ) dut (
    .clk  (clk),
    .r    (r),
    .req  (req),
    .r1   (r1),
    .r2   (r2),
    .ready(ready),
    .cause(cause)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, actual cyc=%0d required finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check3(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: {r1,r2,ready} actual=%b required=%b (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check2(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: cause actual=%b required=%b (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int at, input logic [1:0] c);
    ev_t e;
    e.kind  = kind;
    e.cyc   = at;
    e.cause = c;
    sb_q.push_back(e);
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s: pending events actual=%0d required=0 after %0d cycles",
               name, sb_q.size(), budget);
      sb_q.delete();
    end
  endtask

  task automatic got_event(input int kind);
    ev_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: kind actual=%0d at cyc %0d, required none", kind, cyc);
    end else begin
      e = sb_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.cause !== cause) begin
        errors++;
        $display("FAIL event: actual kind=%0d cyc=%0d cause=%b required kind=%0d cyc=%0d cause=%b",
                 kind, cyc, cause, e.kind, e.cyc, e.cause);
      end
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      checks++;
      if (r1 === 1'b0 && r2 !== 1'b0) begin
        errors++;
        $display("FAIL order: r1=%b r2=%b required r2=0 when r1=0 (cyc %0d)", r1, r2, cyc);
      end
      checks++;
      if (ready !== ~r1) begin
        errors++;
        $display("FAIL ready_eq: ready=%b required=%b (cyc %0d)", ready, ~r1, cyc);
      end
      if (sb_en) begin
        if (prev_r2 && !r2) got_event(R2F);
        if (!prev_rdy && ready) got_event(RDY);
      end
      prev_r2  = r2;
      prev_rdy = ready;
    end
  end

  initial begin
    int e;
    int c;
    r   = 1'b0;
    req = 1'b0;

    // 1: power-on reset, values must appear without any clock edge
    #1 r = 1'b1;
    #1;
    check3("por_async", {r1, r2, ready}, 3'b110);
    check2("por_async_cause", cause, 2'b01);
    repeat (3) @(negedge clk);
    check3("por_hold", {r1, r2, ready}, 3'b110);
    r = 1'b0;
    push(R2F, cyc + 10, 2'b01);
    push(RDY, cyc + 14, 2'b01);
    drain("por_seq", 30);
    check3("por_run", {r1, r2, ready}, 3'b001);

    // 2: single-cycle soft reset from RUN
    @(negedge clk);
    req = 1'b1;
    e = cyc + 1;
    push(R2F, e + 8, 2'b10);
    push(RDY, e + 12, 2'b10);
    @(negedge clk);
    req = 1'b0;
    check3("soft_assert", {r1, r2, ready}, 3'b110);
    check2("soft_cause", cause, 2'b10);
    drain("soft_seq", 30);

    // 3: req held 5 cycles, release timed from last high edge
    @(negedge clk);
    req = 1'b1;
    e = cyc + 1;
    repeat (5) @(negedge clk);
    req = 1'b0;
    check3("held_assert", {r1, r2, ready}, 3'b110);
    push(R2F, e + 4 + 8, 2'b10);
    push(RDY, e + 4 + 12, 2'b10);
    drain("held_seq", 30);

    // 5: r and req together, req outlasts r by 3 edges
    @(negedge clk);
    r   = 1'b1;
    req = 1'b1;
    #1;
    check3("both_assert", {r1, r2, ready}, 3'b110);
    check2("both_cause", cause, 2'b01);
    repeat (2) @(negedge clk);
    r = 1'b0;
    c = cyc;
    repeat (3) @(negedge clk);
    req = 1'b0;
    push(R2F, c + 3 + 8, 2'b01);
    push(RDY, c + 3 + 12, 2'b01);
    drain("both_seq", 30);
    check2("both_cause_end", cause, 2'b01);

    // 4: async abort while in REL2
    @(negedge clk);
    req = 1'b1;
    e = cyc + 1;
    push(R2F, e + 8, 2'b10);
    @(negedge clk);
    req = 1'b0;
    repeat (9) @(negedge clk);
    check3("rel2_state", {r1, r2, ready}, 3'b100);
    #1 r = 1'b1;
    #1;
    check3("abort_async", {r1, r2, ready}, 3'b110);
    check2("abort_cause", cause, 2'b01);
    repeat (2) @(negedge clk);
    r = 1'b0;
    push(R2F, cyc + 10, 2'b01);
    push(RDY, cyc + 14, 2'b01);
    drain("abort_seq", 30);

    // 6: random r/req, invariants checked by the monitor
    sb_en = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      r   = ($urandom_range(0, 15) == 0);
      req = ($urandom_range(0, 7) == 0);
    end
    @(negedge clk);
    r   = 1'b0;
    req = 1'b0;
    repeat (30) @(negedge clk);
    check3("rand_settle", {r1, r2, ready}, 3'b001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
